// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one bus among N requesters over the req/done/dly/gnt protocol.
// Ownership moves through IDLE/BUSY/WAIT/FREE with a one-cycle turnaround and a bounded hold time.
module bus_rr_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 done,
    input  logic                 dly,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 bus_busy,
    output logic                 timeout_err
);

    localparam int unsigned ID_W  = $clog2(N);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_WAIT = 2'd2,
        ST_FREE = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [N-1:0]      gnt_nxt;
    logic [ID_W-1:0]   id_nxt;
    logic [ID_W-1:0]   last, last_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              terr_nxt;

    logic [ID_W-1:0]   win;
    logic              win_vld;
    logic              at_limit;

    // Rotating search starting just after the previous owner, so it ends with lowest priority
    always_comb begin
        logic [ID_W-1:0] cand;
        win     = last;
        win_vld = 1'b0;
        cand    = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = ID_W'((32'(last) + i) % N);
            if (!win_vld && req[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
    end

    assign at_limit = (cnt == CNT_W'(TIMEOUT - 1));

    // State and grant registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            gnt         <= '0;
            gnt_id      <= '0;
            last        <= ID_W'(N - 1);
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            gnt         <= gnt_nxt;
            gnt_id      <= id_nxt;
            last        <= last_nxt;
            cnt         <= cnt_nxt;
            timeout_err <= terr_nxt;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        id_nxt    = gnt_id;
        last_nxt  = last;
        cnt_nxt   = cnt;
        terr_nxt  = 1'b0;

        unique case (state)
            ST_IDLE, ST_FREE: begin
                gnt_nxt = '0;
                if (win_vld) begin
                    state_nxt = ST_BUSY;
                    gnt_nxt   = N'(1) << win;
                    id_nxt    = win;
                    last_nxt  = win;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_BUSY: begin
                if (done && !dly) begin
                    state_nxt = ST_FREE;
                    gnt_nxt   = '0;
                end else if (at_limit) begin
                    state_nxt = ST_FREE;
                    gnt_nxt   = '0;
                    terr_nxt  = 1'b1;
                end else begin
                    state_nxt = done ? ST_WAIT : ST_BUSY;
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end

            ST_WAIT: begin
                if (!dly) begin
                    state_nxt = ST_FREE;
                    gnt_nxt   = '0;
                end else if (at_limit) begin
                    state_nxt = ST_FREE;
                    gnt_nxt   = '0;
                    terr_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    // Decoded purely from the state register so it tracks gnt without glitches
    always_comb begin
        bus_busy = 1'b0;
        if (state == ST_BUSY || state == ST_WAIT) begin
            bus_busy = 1'b1;
        end
    end

    property p_gnt_onehot0;
        @(posedge clk) disable iff (!rst_n) $onehot0(gnt);
    endproperty
    a_gnt_onehot0: assert property (p_gnt_onehot0);

    property p_gnt_matches_busy;
        @(posedge clk) disable iff (!rst_n) ((gnt != '0) == bus_busy);
    endproperty
    a_gnt_matches_busy: assert property (p_gnt_matches_busy);

endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Round-robin bus arbiter that shares one bus among N requesters, using the bus protocol the team's bus FSM already uses (req/done/dly/gnt). It tracks ownership through IDLE, BUSY, WAIT and FREE states and picks the next owner fairly. It enforces a one-cycle turnaround between owners and bounds how long any one owner can hold the bus. It sits between the requesting masters and the shared bus.

## Interface
- N, default 4, number of requesters (legal range 2..16)
- TIMEOUT, default 16, maximum cycles a grant may be held in BUSY+WAIT (legal 2..255)
- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  reset, asynchronous, active-low
- req  input  N  per-requester bus request, level-sensitive
- done  input  1  current owner signals transfer complete (sampled only in BUSY)
- dly  input  1  current owner requests extended hold after done (sampled in BUSY with done, and in WAIT)
- gnt  output  N  one-hot grant, registered; all-zero when no owner
- gnt_id  output  clog2(N)  binary index of the current or last owner, registered
- bus_busy  output  1  high in BUSY or WAIT
- timeout_err  output  1  one-cycle pulse when a grant is force-terminated

## Operation
- States: IDLE, BUSY, WAIT, FREE. Only state, gnt, gnt_id, the priority pointer `last`, the hold counter and timeout_err are registered.
- Arbitration (evaluated in IDLE and FREE):
  - Search requesters last+1, last+2, … modulo N.
  - The first one with req set wins.
  - The winner becomes `last` on entry to BUSY.
- IDLE:
  - req==0: stay.
  - Otherwise: go to BUSY; gnt=onehot(winner), gnt_id=winner, counter=0.
- BUSY (gnt held):
  - done=0: stay, counter+1.
  - done=1, dly=1: go to WAIT, gnt held, counter+1.
  - done=1, dly=0: go to FREE, gnt=0.
- WAIT (gnt held):
  - dly=1: stay, counter+1.
  - dly=0: go to FREE, gnt=0.
- Timeout:
  - Applies in BUSY or WAIT when counter==TIMEOUT-1 and the cycle is not a normal exit to FREE.
  - Force FREE, gnt=0, timeout_err=1 for that FREE cycle.
  - A normal exit on the limit cycle (BUSY with done=1, dly=0; or WAIT with dly=0) takes precedence, and no error is flagged.
  - done=1 with dly=1 on the limit cycle is a timeout.
- FREE:
  - Lasts exactly one cycle with gnt=0 (bus turnaround).
  - req!=0: go to BUSY with a new winner. The just-released owner has the lowest priority, and may win again only if it is the sole requester.
  - req==0: go to IDLE.
- req changes while granted (including the owner dropping its req) are ignored. A grant ends only via done/dly or timeout.
- done and dly are ignored in IDLE and FREE. dly is ignored in BUSY when done=0.
- gnt_id keeps the last owner's index in IDLE and FREE.
- Counter width is clog2(TIMEOUT+1). It never wraps, because the timeout forces an exit first.

## Timing
- Reset (asynchronous assert, any state): state=IDLE, gnt=0, gnt_id=0, bus_busy=0, timeout_err=0, last=N-1, counter=0. After reset, requester 0 has highest priority.
- Reset asserted mid-BUSY or mid-WAIT drops gnt immediately (no clock needed). The first post-reset grant follows the reset priority.
- Latency from req rising in IDLE to gnt: 1 clock.
- Latency from done (dly=0) to gnt low: 1 clock.
- Gap between consecutive owners: exactly 1 FREE cycle.
- Grant duration is at most TIMEOUT cycles, counted from the first BUSY cycle to the last cycle before FREE.
- bus_busy is combinational from the state register only; it is glitch-free relative to gnt.

## Test plan
- Handoff, N=4: reset, req=0101 → next cycle gnt=0001, gnt_id=0. Pulse done (dly=0) → gnt=0000 for one cycle. Then gnt=0100, gnt_id=2.
- Fairness: req=1111 held, done pulsed on the 2nd BUSY cycle of each grant → gnt sequence 0001,0010,0100,1000,0001, separated by single zero cycles.
- Wait path: grant 0010, then done=1 with dly=1 → WAIT, gnt stays 0010. dly held 3 more cycles then 0 → gnt=0000 next cycle, bus_busy falls at the same time.
- Timeout, TIMEOUT=8: grant 1000, done never asserted → gnt high exactly 8 cycles, then timeout_err=1 for one cycle together with gnt=0000. Repeat with done=1, dly=0 on the 8th cycle → no timeout_err.
- Async reset mid-WAIT with req=1111 → gnt=0000 without a clock edge. After release, the first grant is 0001.
- Sole requester: req=0100 only, done each grant → gnt=0100 is re-granted after each single FREE cycle. Drop req during FREE → state returns to IDLE, gnt stays 0, gnt_id=2.
